// File: rtl/ofdm_pkg.sv
// Shared constants, state type and Gray-to-level helpers for the OFDM subcarrier mapper.
// Levels are plain odd integers; K_MOD scaling happens later in the IFFT path.
package ofdm_pkg;

    localparam int NUM_DATA_SC = 48;
    localparam int LVL_MIN_W   = 4;

    localparam logic [1:0] MOD_BPSK  = 2'd0;
    localparam logic [1:0] MOD_QPSK  = 2'd1;
    localparam logic [1:0] MOD_QAM16 = 2'd2;
    localparam logic [1:0] MOD_QAM64 = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mapper_state_e;

    function automatic logic [2:0] n_bpsc(input logic [1:0] mod);
        case (mod)
            MOD_BPSK:  return 3'd1;
            MOD_QPSK:  return 3'd2;
            MOD_QAM16: return 3'd4;
            default:   return 3'd6;
        endcase
    endfunction

    // g is {first bit, second bit} in arrival order
    function automatic logic signed [LVL_MIN_W-1:0] gray2_lvl(input logic [1:0] g);
        case (g)
            2'b00:   return -4'sd3;
            2'b01:   return -4'sd1;
            2'b11:   return 4'sd1;
            default: return 4'sd3;
        endcase
    endfunction

    function automatic logic signed [LVL_MIN_W-1:0] gray3_lvl(input logic [2:0] g);
        case (g)
            3'b000:  return -4'sd7;
            3'b001:  return -4'sd5;
            3'b011:  return -4'sd3;
            3'b010:  return -4'sd1;
            3'b110:  return 4'sd1;
            3'b111:  return 4'sd3;
            3'b101:  return 4'sd5;
            default: return 4'sd7;
        endcase
    endfunction

endpackage

// File: rtl/qam_level_lut.sv
// Combinational Gray-coded constellation lookup; grp_i[0] is the first bit of the group (b0).
module qam_level_lut
    import ofdm_pkg::*;
#(
    parameter int LVL_W = LVL_MIN_W
) (
    input  logic [1:0]              mod_i,
    input  logic [5:0]              grp_i,
    output logic signed [LVL_W-1:0] i_lvl_o,
    output logic signed [LVL_W-1:0] q_lvl_o
);

    always_comb begin
        i_lvl_o = '0;
        q_lvl_o = '0;
        case (mod_i)
            MOD_BPSK: begin
                i_lvl_o = grp_i[0] ? LVL_W'(1) : LVL_W'(-1);
            end
            MOD_QPSK: begin
                i_lvl_o = grp_i[0] ? LVL_W'(1) : LVL_W'(-1);
                q_lvl_o = grp_i[1] ? LVL_W'(1) : LVL_W'(-1);
            end
            MOD_QAM16: begin
                i_lvl_o = LVL_W'(gray2_lvl({grp_i[0], grp_i[1]}));
                q_lvl_o = LVL_W'(gray2_lvl({grp_i[2], grp_i[3]}));
            end
            default: begin
                i_lvl_o = LVL_W'(gray3_lvl({grp_i[0], grp_i[1], grp_i[2]}));
                q_lvl_o = LVL_W'(gray3_lvl({grp_i[3], grp_i[4], grp_i[5]}));
            end
        endcase
    end

endmodule

// File: rtl/ofdm_qam_mapper.sv
// 802.11a subcarrier mapper: groups serial interleaved bits into N_BPSC words, Gray-maps them
// to I/Q levels and tags each output with its data-subcarrier index within the OFDM symbol.
module ofdm_qam_mapper
    import ofdm_pkg::*;
#(
    parameter int NUM_SC = NUM_DATA_SC,
    parameter int LVL_W  = LVL_MIN_W
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [1:0]              Rate,
    input  logic                    x,
    input  logic                    Valid_in,
    output logic signed [LVL_W-1:0] I,
    output logic signed [LVL_W-1:0] Q,
    output logic                    Valid,
    output logic [5:0]              Sc_idx,
    output logic                    Last_sc,
    output mapper_state_e           Dbg_state
);

    localparam logic [5:0] SC_LAST = 6'(NUM_SC - 1);

    mapper_state_e           state_q, state_d;
    logic [1:0]              mod_q, mod_d;
    logic [2:0]              bit_cnt_q, bit_cnt_d;
    logic [5:0]              shreg_q, shreg_d;
    logic [5:0]              sc_cnt_q, sc_cnt_d;
    logic signed [LVL_W-1:0] i_q, i_d, q_q, q_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic [5:0]              sc_idx_q, sc_idx_d;

    logic [5:0]              grp_w;
    logic [2:0]              last_bit_w;
    logic signed [LVL_W-1:0] lut_i_w, lut_q_w;

    // The group seen by the LUT already contains the bit arriving this cycle,
    // so the mapped value can be registered on the same edge that captures it.
    always_comb begin
        grp_w            = shreg_q;
        grp_w[bit_cnt_q] = x;
        last_bit_w       = n_bpsc(mod_q) - 3'd1;
    end

    qam_level_lut #(
        .LVL_W (LVL_W)
    ) u_lut (
        .mod_i   (mod_q),
        .grp_i   (grp_w),
        .i_lvl_o (lut_i_w),
        .q_lvl_o (lut_q_w)
    );

    always_comb begin
        state_d   = state_q;
        mod_d     = mod_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sc_cnt_d  = sc_cnt_q;
        i_d       = i_q;
        q_d       = q_q;
        sc_idx_d  = sc_idx_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                shreg_d   = '0;
                sc_cnt_d  = '0;
                if (Start) begin
                    state_d = ST_RUN;
                    mod_d   = Rate;
                end
            end
            ST_RUN: begin
                // Abort takes priority over a group completing in the same cycle
                if (!Start) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    sc_cnt_d  = '0;
                end else if (Valid_in) begin
                    if (bit_cnt_q == last_bit_w) begin
                        bit_cnt_d = '0;
                        shreg_d   = '0;
                        valid_d   = 1'b1;
                        i_d       = lut_i_w;
                        q_d       = lut_q_w;
                        sc_idx_d  = sc_cnt_q;
                        last_d    = (sc_cnt_q == SC_LAST);
                        if (sc_cnt_q == SC_LAST) begin
                            sc_cnt_d = '0;
                            mod_d    = Rate;
                        end else begin
                            sc_cnt_d = sc_cnt_q + 6'd1;
                        end
                    end else begin
                        shreg_d   = grp_w;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            mod_q     <= MOD_BPSK;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sc_cnt_q  <= '0;
            i_q       <= '0;
            q_q       <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            sc_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            mod_q     <= mod_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sc_cnt_q  <= sc_cnt_d;
            i_q       <= i_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            sc_idx_q  <= sc_idx_d;
        end
    end

    assign I         = i_q;
    assign Q         = q_q;
    assign Valid     = valid_q;
    assign Sc_idx    = sc_idx_q;
    assign Last_sc   = last_q;
    assign Dbg_state = state_q;

endmodule

// File: tb/tb_ofdm_qam_mapper.sv
// Self-checking bench for ofdm_qam_mapper: Gray-decode reference model feeding an expected queue.
module tb_ofdm_qam_mapper;
    import ofdm_pkg::*;

    localparam int W = 15;  // {I[3:0], Q[3:0], Sc_idx[5:0], Last_sc}

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              Start = 1'b0;
    logic [1:0]        Rate = 2'd0;
    logic              x = 1'b0;
    logic              Valid_in = 1'b0;
    logic signed [3:0] I, Q;
    logic              Valid;
    logic [5:0]        Sc_idx;
    logic              Last_sc;
    mapper_state_e     Dbg_state;

    ofdm_qam_mapper #(
        .NUM_SC (48),
        .LVL_W  (4)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Rate      (Rate),
        .x         (x),
        .Valid_in  (Valid_in),
        .I         (I),
        .Q         (Q),
        .Valid     (Valid),
        .Sc_idx    (Sc_idx),
        .Last_sc   (Last_sc),
        .Dbg_state (Dbg_state)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           checks = 0;
    int           errors = 0;

    // reference model state
    logic [1:0] m_mod = 2'd0;
    int         m_nbits = 1;
    int         m_sc = 0;
    int         mcnt = 0;
    logic [5:0] mbits = '0;

    function automatic int bits_for(input logic [1:0] mod);
        case (mod)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 6;
        endcase
    endfunction

    // Gray -> binary -> odd integer level, b[first] is the most significant Gray bit
    function automatic int gray_level(input logic [5:0] b, input int first, input int m);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        for (int k = 0; k < m; k++) begin
            acc = acc ^ b[first + k];
            n   = n * 2 + int'(acc);
        end
        return 2 * n - ((1 << m) - 1);
    endfunction

    function automatic logic [W-1:0] model_entry(input int nbits, input logic [5:0] b,
                                                 input int sc);
        int   half, iv, qv;
        half = (nbits == 1) ? 1 : nbits / 2;
        iv   = gray_level(b, 0, half);
        qv   = (nbits == 1) ? 0 : gray_level(b, half, half);
        return {4'(iv), 4'(qv), 6'(sc), (sc == 47)};
    endfunction

    always @(negedge Clk) begin
        logic [W-1:0] got, e;
        int           ec;
        if (Valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: I=%0d Q=%0d sc=%0d at cycle %0d, expected none",
                         I, Q, Sc_idx, cyc);
            end else begin
                e   = exp_q.pop_front();
                ec  = exp_cyc_q.pop_front();
                got = {I, Q, Sc_idx, Last_sc};
                if (got !== e) begin
                    errors++;
                    $display("FAIL output: got I=%0d Q=%0d sc=%0d last=%0b, expected I=%0d Q=%0d sc=%0d last=%0b",
                             $signed(got[14:11]), $signed(got[10:7]), got[6:1], got[0],
                             $signed(e[14:11]), $signed(e[10:7]), e[6:1], e[0]);
                end
                checks++;
                if (cyc !== ec) begin
                    errors++;
                    $display("FAIL latency: valid at cycle %0d, expected cycle %0d", cyc, ec);
                end
            end
        end else begin
            checks++;
            if (Last_sc !== 1'b0) begin
                errors++;
                $display("FAIL last_without_valid: Last_sc=%0b, expected 0", Last_sc);
            end
        end
    end

    // driver tasks
    task automatic model_clear();
        mcnt  = 0;
        mbits = '0;
    endtask

    task automatic start_frame(input logic [1:0] rate);
        @(negedge Clk);
        Start    = 1'b1;
        Rate     = rate;
        Valid_in = 1'b0;
        m_mod    = rate;
        m_nbits  = bits_for(rate);
        m_sc     = 0;
        model_clear();
        @(negedge Clk);
        Valid_in = 1'b0;
    endtask

    task automatic stop_frame();
        @(negedge Clk);
        Start    = 1'b0;
        Valid_in = 1'b0;
        model_clear();
        @(negedge Clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge Clk);
        x           = b;
        Valid_in    = 1'b1;
        mbits[mcnt] = b;
        mcnt++;
        if (mcnt == m_nbits) begin
            exp_q.push_back(model_entry(m_nbits, mbits, m_sc));
            exp_cyc_q.push_back(cyc + 1);
            model_clear();
            if (m_sc == 47) begin
                m_sc    = 0;
                m_mod   = Rate;
                m_nbits = bits_for(Rate);
            end else begin
                m_sc++;
            end
        end
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge Clk);
            Valid_in = 1'b0;
        end
    endtask

    task automatic send_group(input logic [5:0] b, input int max_gap);
        int n;
        n = m_nbits;
        for (int k = 0; k < n; k++) begin
            send_bit(b[k]);
            if (max_gap > 0) gap($urandom_range(0, max_gap));
        end
    endtask

    task automatic drain();
        int waited;
        @(negedge Clk);
        Valid_in = 1'b0;
        waited   = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d outputs still pending, expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if ({I, Q, Valid, Sc_idx, Last_sc} !== 15'd0) begin
            errors++;
            $display("FAIL %s: I=%0d Q=%0d Valid=%0b Sc_idx=%0d Last_sc=%0b, expected all 0",
                     tag, I, Q, Valid, Sc_idx, Last_sc);
        end
        checks++;
        if (Dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL %s_state: state=%0d, expected IDLE", tag, Dbg_state);
        end
    endtask

    // scenarios
    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check_outputs_zero("reset_state");
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_bpsk();
        start_frame(2'd0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        drain();
        stop_frame();
    endtask

    task automatic test_qam16_gaps();
        start_frame(2'd2);
        send_group(6'b00_1001, 0);
        gap(2);
        send_group(6'b00_1001, 3);
        send_group(6'(($urandom_range(0, 15))), 2);
        drain();
        stop_frame();
    endtask

    task automatic test_qam64_symbol();
        start_frame(2'd3);
        send_group(6'b110001, 0);
        for (int g = 1; g < 48; g++) send_group(6'($urandom_range(0, 63)), (g % 3 == 0) ? 2 : 0);
        send_group(6'($urandom_range(0, 63)), 0);
        drain();
        stop_frame();
    endtask

    task automatic test_rate_switch();
        start_frame(2'd1);
        for (int g = 0; g < 20; g++) send_group(6'($urandom_range(0, 3)), 0);
        @(negedge Clk);
        Rate     = 2'd3;
        Valid_in = 1'b0;
        for (int g = 20; g < 48; g++) send_group(6'($urandom_range(0, 3)), 0);
        checks++;
        if (m_nbits != 6) begin
            errors++;
            $display("FAIL rate_switch_model: bits per group %0d, expected 6", m_nbits);
        end
        send_group(6'b110001, 1);
        drain();
        stop_frame();
        Rate = 2'd0;
    endtask

    task automatic test_abort();
        start_frame(2'd2);
        send_bit(1'b1);
        send_bit(1'b0);
        stop_frame();
        checks++;
        if (Dbg_state !== ST_IDLE || Valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: state=%0d Valid=%0b, expected IDLE and 0", Dbg_state, Valid);
        end
        // abort coinciding with the last bit of a group
        start_frame(2'd2);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge Clk);
        x        = 1'b1;
        Valid_in = 1'b1;
        Start    = 1'b0;
        model_clear();
        gap(3);
        checks++;
        if (Dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_wins: state=%0d, expected IDLE", Dbg_state);
        end
        start_frame(2'd2);
        send_group(6'b00_1100, 0);
        drain();
        stop_frame();
    endtask

    task automatic test_reset_mid_frame();
        start_frame(2'd3);
        send_group(6'b110001, 0);
        send_group(6'b011010, 0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        gap(2);
        #2;
        Reset    = 1'b0;
        Start    = 1'b0;
        Valid_in = 1'b0;
        #1;
        check_outputs_zero("reset_mid_frame");
        exp_q.delete();
        exp_cyc_q.delete();
        model_clear();
        @(negedge Clk);
        Reset = 1'b1;
        start_frame(2'd3);
        send_group(6'b011110, 0);
        drain();
        stop_frame();
    endtask

    initial begin
        test_reset();
        test_bpsk();
        test_qam16_gaps();
        test_qam64_symbol();
        test_rate_switch();
        test_abort();
        test_reset_mid_frame();
        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
